// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_arbiter
//  Description : Shares one single-port bus master between the instruction
//                fetch port and the data memory port of the pipeline. Each
//                pipeline cycle the data access (older instruction) is done
//                first, then the fetch; the pipeline is stalled until both
//                have completed and then released for exactly one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              im_read_mem,
    input  logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_dataout,
    input  logic              dm_read_mem,
    input  logic              dm_write_mem,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [3:0]        dm_web,
    input  logic [DATA_W-1:0] dm_datain,
    output logic [DATA_W-1:0] dm_dataout,
    output logic              bus_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_web,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    // Counter only has to reach TIMEOUT_CYC-1, so log2 bits are enough.
    localparam int              CNT_W   = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DM_REQ  = 3'd1,
        S_DM_WAIT = 3'd2,
        S_IM_REQ  = 3'd3,
        S_IM_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   im_addr_q;
    logic                im_pend_q;
    logic                dm_we_q;
    logic [DATA_W-1:0]   im_dataout_q;
    logic [DATA_W-1:0]   dm_dataout_q;
    logic                bus_req_q;
    logic                bus_we_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [3:0]          bus_web_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic                bus_err_q;

    logic                w_dm_pend;
    logic                w_any_req;
    logic                w_wait_end;
    logic                w_timeout;
    logic                w_dm_end;
    logic                w_im_end;
    logic [DATA_W-1:0]   w_rdata;

    assign w_dm_pend  = dm_read_mem | dm_write_mem;
    assign w_any_req  = im_read_mem | w_dm_pend;
    // A WAIT state ends on rvalid or when the counter has run out.
    assign w_wait_end = bus_rvalid | (cnt_q == CNT_MAX);
    assign w_timeout  = ((state_q == S_DM_WAIT) || (state_q == S_IM_WAIT))
                        && !bus_rvalid && (cnt_q == CNT_MAX);
    // Completion either straight from REQ (gnt and rvalid together) or from WAIT.
    assign w_dm_end   = ((state_q == S_DM_REQ) && bus_gnt && bus_rvalid)
                        || ((state_q == S_DM_WAIT) && w_wait_end);
    assign w_im_end   = ((state_q == S_IM_REQ) && bus_gnt && bus_rvalid)
                        || ((state_q == S_IM_WAIT) && w_wait_end);
    // A timed-out read returns zero.
    assign w_rdata    = bus_rvalid ? bus_rdata : '0;

    assign im_dataout = im_dataout_q;
    assign dm_dataout = dm_dataout_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_web    = bus_web_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_err    = bus_err_q;

    // Stall follows the live request in IDLE so the pipeline freezes in the
    // same cycle it asks for memory; it is released only in DONE.
    always_comb begin
        bus_stall = 1'b1;
        case (state_q)
            S_IDLE:  bus_stall = w_any_req;
            S_DONE:  bus_stall = 1'b0;
            default: bus_stall = 1'b1;
        endcase
    end

    // Sequencer: request latch, bus handshake, data capture and timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            im_addr_q    <= '0;
            im_pend_q    <= 1'b0;
            dm_we_q      <= 1'b0;
            im_dataout_q <= '0;
            dm_dataout_q <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_web_q    <= 4'b1111;
            bus_wdata_q  <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_any_req) begin
                        im_addr_q <= im_addr;
                        im_pend_q <= im_read_mem;
                        dm_we_q   <= dm_write_mem;
                        bus_req_q <= 1'b1;
                        if (w_dm_pend) begin
                            // Data fields are held directly in the bus registers.
                            state_q     <= S_DM_REQ;
                            bus_we_q    <= dm_write_mem;
                            bus_addr_q  <= dm_addr;
                            bus_web_q   <= dm_write_mem ? dm_web : 4'b1111;
                            bus_wdata_q <= dm_datain;
                        end else begin
                            state_q    <= S_IM_REQ;
                            bus_we_q   <= 1'b0;
                            bus_addr_q <= im_addr;
                            bus_web_q  <= 4'b1111;
                        end
                    end
                end
                S_DM_REQ: begin
                    if (bus_gnt && !bus_rvalid) begin
                        state_q   <= S_DM_WAIT;
                        bus_req_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                S_IM_REQ: begin
                    if (bus_gnt && !bus_rvalid) begin
                        state_q   <= S_IM_WAIT;
                        bus_req_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                S_DM_WAIT, S_IM_WAIT: begin
                    if (!w_wait_end) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // Data access finished: capture load data, then fetch or finish.
            if (w_dm_end) begin
                if (!dm_we_q) begin
                    dm_dataout_q <= w_rdata;
                end
                if (im_pend_q) begin
                    state_q    <= S_IM_REQ;
                    bus_req_q  <= 1'b1;
                    bus_we_q   <= 1'b0;
                    bus_addr_q <= im_addr_q;
                    bus_web_q  <= 4'b1111;
                end else begin
                    state_q   <= S_DONE;
                    bus_req_q <= 1'b0;
                end
            end

            // Fetch finished: capture instruction and release the pipeline.
            if (w_im_end) begin
                im_dataout_q <= w_rdata;
                state_q      <= S_DONE;
                bus_req_q    <= 1'b0;
            end

            // Sticky until reset.
            if (w_timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-port system-bus master between the pipeline's instruction-fetch port and data-memory port.
- Drives the pipeline's bus_stall input.
- Serialises each pipeline cycle's accesses: data first (older instruction), then fetch.
- Returns captured read data; releases the stall for exactly one cycle once both accesses have completed.
- Sits between the CPU core and the bus interconnect.

Parameters:
- ADDR_W, 32, bus/CPU address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 16, max cycles waiting for bus_rvalid before the access is force-completed (must be >= 2).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- im_read_mem  input  1  fetch request (level)
- im_addr  input  ADDR_W  fetch address
- im_dataout  output  DATA_W  fetched instruction (registered)
- dm_read_mem  input  1  data read request (level)
- dm_write_mem  input  1  data write request (level)
- dm_addr  input  ADDR_W  data address
- dm_web  input  4  byte write enables, active-low
- dm_datain  input  DATA_W  write data
- dm_dataout  output  DATA_W  load data (registered)
- bus_stall  output  1  freezes pipeline when 1
- bus_req  output  1  bus request
- bus_we  output  1  1 = write
- bus_addr  output  ADDR_W  bus address
- bus_web  output  4  byte enables, active-low; 4'b1111 on reads
- bus_wdata  output  DATA_W  write data
- bus_gnt  input  1  request accepted this cycle
- bus_rvalid  input  1  access complete; rdata valid for reads
- bus_rdata  input  DATA_W  read data
- bus_err  output  1  sticky timeout flag

Behaviour:
- States: IDLE, DM_REQ, DM_WAIT, IM_REQ, IM_WAIT, DONE.
- Reset values: state IDLE; im_dataout=0; dm_dataout=0; bus_req=0; bus_we=0; bus_addr=0; bus_web=4'b1111; bus_wdata=0; bus_err=0; timeout counter=0; latched request fields=0.
- Reset asserted mid-operation aborts immediately: bus_req drops asynchronously, pending accesses are discarded.
- A data access is pending when dm_read_mem or dm_write_mem is 1. If both are 1, the write wins.
- bus_stall is combinational:
  - In IDLE it equals (im_read_mem | pending data access).
  - It is 1 in DM_REQ, DM_WAIT, IM_REQ and IM_WAIT.
  - It is 0 in DONE.
- IDLE, on any request:
  - Latch im_addr, dm_addr, dm_web, dm_datain, the read/write kind and im_read_mem.
  - Go to DM_REQ if a data access is pending, else IM_REQ.
  - With no request, stay in IDLE; bus_stall=0.
- DM_REQ:
  - Drive bus_req=1, bus_addr=latched dm_addr, bus_we=write flag.
  - Writes: bus_web=latched dm_web, bus_wdata=latched dm_datain. Reads: bus_web=4'b1111.
  - Hold all bus outputs stable until bus_gnt=1, then go to DM_WAIT and drop bus_req the next cycle.
- DM_WAIT:
  - bus_req=0; the counter increments each cycle.
  - On bus_rvalid: a read loads dm_dataout <= bus_rdata; a write leaves dm_dataout unchanged.
  - Next state is IM_REQ if the latched fetch is pending, else DONE.
- IM_REQ / IM_WAIT:
  - Same handshake as DM_REQ / DM_WAIT with bus_we=0, bus_addr=latched im_addr, bus_web=4'b1111.
  - On bus_rvalid, im_dataout <= bus_rdata, then go to DONE.
- bus_gnt and bus_rvalid in the same cycle while in a REQ state: complete the access directly and skip the WAIT state.
- Timeout:
  - The counter clears on entry to each WAIT state.
  - If the counter reaches TIMEOUT_CYC-1 without bus_rvalid, the access completes with captured data 0 (reads) and bus_err is set.
  - bus_err clears only on reset.
- DONE:
  - One cycle with bus_stall=0; the pipeline advances using the registered outputs.
  - Always returns to IDLE. New requests are only sampled in IDLE.
- bus_rvalid outside a WAIT state is ignored.
- im_dataout and dm_dataout hold their last values between completions.
- Minimum per-pipeline-cycle latency:
  - Fetch only: 3 cycles (IDLE, IM_REQ with same-cycle rvalid, DONE).
  - Data plus fetch: 4 cycles.

Test Plan:
- Fetch only, im_addr=0x0000_0010, gnt in the first REQ cycle, rvalid 2 cycles later with rdata=0x0010_0093 → bus_addr=0x10, bus_we=0; bus_stall high 4 cycles then low 1 cycle; im_dataout=0x0010_0093.
- Load plus fetch, dm_addr=0x0001_0004, im_addr=0x20 → data bus transaction precedes fetch; dm_dataout=0xDEAD_BEEF; im_dataout from the second rvalid; bus_stall low exactly in DONE.
- Store, dm_web=4'b1100, dm_datain=0x0000_ABCD → bus_we=1, bus_web=4'b1100, bus_wdata=0x0000_ABCD held through 3 cycles of gnt=0; dm_dataout unchanged.
- No rvalid in DM_WAIT with TIMEOUT_CYC=16 → after 16 WAIT cycles dm_dataout=0, bus_err=1, fetch proceeds; bus_err stays 1 until rst=0.
- rst driven low during IM_WAIT → bus_req=0, state IDLE, outputs 0 immediately; a later rvalid pulse is ignored.
- Same-cycle gnt+rvalid for fetch → 3-cycle pipeline cycle; bus_req high exactly one cycle.
